demux_1x6_64bit: RTL and testbench
==================================

Name: demux_1x6_64bit

Overview:
Registered 1-to-6 distributor for 64-bit datapath values; the inverse of the 6-way selector used on the datapath.
- Accepts one word per handshake on a single input channel.
- Steers the word by a 3-bit select into one of six single-entry output holding registers, each with its own valid/ready pair.
- Sits between a shared result source and up to six independent consumers (e.g. writeback targets), providing per-destination backpressure.

Parameters:
WIDTH, 64, data width of input and every output channel

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
S  input  3  destination select; 0..5 valid, 6..7 illegal
A  input  WIDTH  input data word
in_valid  input  1  input word and S present
in_ready  output  1  block can accept the word this cycle
X0..X5  output  WIDTH each  output channel data, registered
X_valid  output  6  bit n: Xn holds an undelivered word
X_ready  input  6  bit n: consumer n takes Xn this cycle
err  output  1  one-cycle pulse: illegal S accepted and dropped
drop_cnt  output  8  count of illegal-select words dropped, saturating

Behaviour:
- Reset (async assert, sync release to the clk domain):
  - X_valid = 0, X0..X5 = 0, err = 0, drop_cnt = 0.
  - Any pending words are discarded.
- Input acceptance: accept = in_valid & in_ready.
  - For S in 0..5: in_ready = ~X_valid[S] | X_ready[S]. This is combinational and allows pass-through when the slot drains in the same cycle.
  - For S in 6..7: in_ready = 1 (word always consumed).
  - in_ready depends only on S, X_valid and X_ready, never on in_valid.
- Write on accept with S = n (0..5):
  - Xn <= A and X_valid[n] <= 1 at that edge.
  - Latency is one cycle: the word is visible on Xn the cycle after acceptance.
- Output drain: X_valid[n] & X_ready[n] completes delivery.
  - If no new write to n occurs, X_valid[n] <= 0 and Xn holds its old value (data not cleared).
- Simultaneous drain of n and accept to n: the new word overwrites Xn and X_valid[n] stays 1. No bubble, no loss.
- Per-channel state (2 states):
  - EMPTY -> FULL on accept to n.
  - FULL -> EMPTY on drain without accept.
  - FULL -> FULL on drain+accept or on hold.
  - EMPTY ignores X_ready[n].
- Channels are independent: a full, stalled channel blocks only inputs selecting it; other channels keep draining.
- Stability: while X_valid[n] = 1 and X_ready[n] = 0, Xn is stable.
- Illegal select: accept with S = 6 or 7:
  - No output changes.
  - err = 1 for exactly the next cycle.
  - drop_cnt increments, saturating at 255.
- err is registered; err = 0 in every cycle not following an illegal accept.
- At most one channel is written per cycle; any number may drain in the same cycle.
- No combinational path from A to any output. in_ready is the only combinational output.

Decomposition:
- Shared package holds:
  - constants NUM_DEST = 6 and SEL_W = 3;
  - SEL_MAX = 3'd5;
  - per-channel state encoding (EMPTY = 1'b0, FULL = 1'b1).
- One sub-module is natural: demux_slot_64bit. It is a single-entry holding register with wr_en, data_in, valid/ready out, and a not-full/drain-aware ready term. It is instantiated six times.
- Top level holds select decode, in_ready mux, err/drop_cnt logic.

Test Plan:
- Reset mid-operation:
  - Stimulus: fill X2 with 64'hDEAD_BEEF_0000_0002 (X_ready = 0), then assert reset asynchronously between edges.
  - Required: X_valid = 6'b000000, X2 = 0 and drop_cnt = 0 immediately; in_ready = 1 after release.
- Basic route:
  - Stimulus: S = 3, A = 64'h0123_4567_89AB_CDEF, in_valid one cycle, X_ready = 6'b111111.
  - Required: next cycle X3 = 64'h0123_4567_89AB_CDEF, X_valid = 6'b001000; following cycle X_valid = 0.
- Backpressure:
  - Stimulus: X_ready = 0; send S = 1, A = 64'h11; then S = 1, A = 64'h22.
  - Required: second word sees in_ready = 0 and X1 stays 64'h11.
  - Stimulus continued: raise X_ready[1] while the second word is still offered.
  - Required: it is accepted that cycle and X1 = 64'h22 next cycle with X_valid[1] remaining 1.
- Independence:
  - Stimulus: X5 full and stalled; send S = 0, A = 64'hAA.
  - Required: in_ready = 1, X0 = 64'hAA next cycle, X5 unchanged.
- Illegal select:
  - Stimulus: 300 back-to-back accepts with S = 7.
  - Required: err pulses each following cycle, X_valid never changes, drop_cnt saturates at 8'd255.
- Full streaming:
  - Stimulus: 6 consecutive words S = 0..5, A = n+1, all X_ready = 1.
  - Required: in_ready held 1 throughout; each Xn = n+1 exactly one cycle after its accept.

Source files
------------

// File: rtl/demux_1x6_64bit_pkg.sv
// ----------------------------------------------------------------------------
// demux_1x6_64bit_pkg
// Shared constants and types for the 1-to-6 registered distributor.
//   NUM_DEST     : number of output channels
//   SEL_W        : width of the destination select
//   SEL_SPAN     : number of select codes (legal and illegal)
//   SEL_MAX      : highest legal select code
//   DROP_W       : width of the illegal-select drop counter
//   DROP_MAX     : drop counter saturation value
//   slot_state_e : per-channel holding register state
// ----------------------------------------------------------------------------
package demux_1x6_64bit_pkg;

    localparam int unsigned NUM_DEST = 6;
    localparam int unsigned SEL_W    = 3;
    localparam int unsigned SEL_SPAN = 2 ** SEL_W;
    localparam int unsigned DROP_W   = 8;

    localparam logic [SEL_W-1:0]  SEL_MAX  = 3'd5;
    localparam logic [DROP_W-1:0] DROP_MAX = 8'd255;

    // Holding register occupancy
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

endpackage : demux_1x6_64bit_pkg

// File: rtl/demux_slot_64bit.sv
// ----------------------------------------------------------------------------
// demux_slot_64bit
// Single-entry output holding register for one distributor channel.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   wr_en        : write data_in this edge (caller guarantees accept_ok_c)
//   data_in      : word to store
//   ready        : consumer takes the held word this cycle
//   valid        : register holds an undelivered word
//   data_out     : held word (retained after delivery, never cleared)
//   accept_ok_c  : combinational; slot can take a word this cycle, counting
//                  a same-cycle drain as free space
// ----------------------------------------------------------------------------
module demux_slot_64bit
    import demux_1x6_64bit_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data_out,
    output logic             accept_ok_c
);

    slot_state_e state;

    // Occupancy and data register; a write wins over a drain so that a
    // simultaneous drain+write keeps the slot FULL with the new word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= EMPTY;
            data_out <= '0;
        end else begin
            if (wr_en) begin
                state    <= FULL;
                data_out <= data_in;
            end else if ((state == FULL) && ready) begin
                state    <= EMPTY;
            end
        end
    end

    assign valid       = (state == FULL);
    assign accept_ok_c = (state == EMPTY) | ready;

endmodule : demux_slot_64bit

// File: rtl/demux_1x6_64bit.sv
// ----------------------------------------------------------------------------
// demux_1x6_64bit
// Registered 1-to-6 distributor: one input word per handshake is steered by S
// into one of six single-entry holding registers, each with its own
// valid/ready pair. Illegal selects (6, 7) are always accepted and dropped,
// flagged by a one-cycle err pulse and counted in a saturating drop counter.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   S            : destination select, 0..5 legal
//   A            : input data word
//   in_valid     : A and S are presented
//   in_ready     : combinational; selected destination can take a word
//   X0..X5       : registered channel data
//   X_valid      : per-channel undelivered-word flags
//   X_ready      : per-channel consumer ready
//   err          : registered pulse, illegal select dropped last cycle
//   drop_cnt     : saturating count of dropped illegal-select words
// ----------------------------------------------------------------------------
module demux_1x6_64bit
    import demux_1x6_64bit_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SEL_W-1:0]    S,
    input  logic [WIDTH-1:0]    A,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [WIDTH-1:0]    X0,
    output logic [WIDTH-1:0]    X1,
    output logic [WIDTH-1:0]    X2,
    output logic [WIDTH-1:0]    X3,
    output logic [WIDTH-1:0]    X4,
    output logic [WIDTH-1:0]    X5,
    output logic [NUM_DEST-1:0] X_valid,
    input  logic [NUM_DEST-1:0] X_ready,
    output logic                err,
    output logic [DROP_W-1:0]   drop_cnt
);

    logic                sel_legal_c;
    logic                accept_c;
    logic                illegal_acc_c;
    logic [NUM_DEST-1:0] slot_ok_c;
    logic [SEL_SPAN-1:0] ready_map_c;
    logic [NUM_DEST-1:0] wr_en_c;
    logic [WIDTH-1:0]    slot_data [NUM_DEST];

    // Ready lookup: legal codes take the slot's drain-aware term, the unused
    // codes are padded with 1 so illegal words are always consumed.
    assign sel_legal_c   = (S <= SEL_MAX);
    assign ready_map_c   = {{(SEL_SPAN - NUM_DEST){1'b1}}, slot_ok_c};
    assign in_ready      = ready_map_c[S];
    assign accept_c      = in_valid & in_ready;
    assign illegal_acc_c = accept_c & ~sel_legal_c;

    // One holding register per destination; at most one write enable is set.
    for (genvar n = 0; n < NUM_DEST; n++) begin : g_slot
        assign wr_en_c[n] = accept_c & (S == SEL_W'(n));

        demux_slot_64bit #(
            .WIDTH       (WIDTH)
        ) u_slot (
            .clk         (clk),
            .reset       (reset),
            .wr_en       (wr_en_c[n]),
            .data_in     (A),
            .ready       (X_ready[n]),
            .valid       (X_valid[n]),
            .data_out    (slot_data[n]),
            .accept_ok_c (slot_ok_c[n])
        );
    end

    assign X0 = slot_data[0];
    assign X1 = slot_data[1];
    assign X2 = slot_data[2];
    assign X3 = slot_data[3];
    assign X4 = slot_data[4];
    assign X5 = slot_data[5];

    // Illegal-select reporting: one-cycle err pulse and saturating counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err      <= 1'b0;
            drop_cnt <= '0;
        end else begin
            err <= illegal_acc_c;
            if (illegal_acc_c && (drop_cnt != DROP_MAX)) begin
                drop_cnt <= drop_cnt + DROP_W'(1);
            end
        end
    end

endmodule : demux_1x6_64bit

// File: tb/tb_demux_1x6_64bit.sv
// ----------------------------------------------------------------------------
// tb_demux_1x6_64bit
// Scoreboard bench for demux_1x6_64bit: the stimulus pushes each accepted
// legal word with its channel; a monitor on the falling edge checks channel
// occupancy, held data, deliveries, err and drop_cnt against its own model.
// ----------------------------------------------------------------------------
module tb_demux_1x6_64bit;

    typedef struct {
        int unsigned chan;
        logic [63:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  S;
    logic [63:0] A;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] X0, X1, X2, X3, X4, X5;
    logic [5:0]  X_valid;
    logic [5:0]  X_ready;
    logic        err;
    logic [7:0]  drop_cnt;

    logic [63:0] xs [6];
    exp_t        sb [$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          mon_idx;
    logic        prev_ill;
    int          exp_drop;

    demux_1x6_64bit #(.WIDTH(64)) dut (
        .clk      (clk),
        .reset    (reset),
        .S        (S),
        .A        (A),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .X0       (X0),
        .X1       (X1),
        .X2       (X2),
        .X3       (X3),
        .X4       (X4),
        .X5       (X5),
        .X_valid  (X_valid),
        .X_ready  (X_ready),
        .err      (err),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    assign xs[0] = X0;
    assign xs[1] = X1;
    assign xs[2] = X2;
    assign xs[3] = X3;
    assign xs[4] = X4;
    assign xs[5] = X5;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Offer one word (called just after a rising edge); returns just after
    // the edge at which it is accepted when exp_rdy is set.
    task automatic send(input logic [2:0] s, input logic [63:0] a, input logic exp_rdy);
        S        = s;
        A        = a;
        in_valid = 1'b1;
        @(negedge clk);
        check("in_ready", 64'(in_ready), 64'(exp_rdy));
        @(posedge clk);
        #1;
        if (exp_rdy && (s <= 3'd5)) sb.push_back('{chan: int'(s), data: a});
        in_valid = 1'b0;
    endtask

    // Monitor: compare model against outputs, pop delivered words.
    always @(negedge clk or posedge reset) begin
        if (reset) begin
            sb.delete();
            prev_ill = 1'b0;
            exp_drop = 0;
        end else begin
            check("err", 64'(err), 64'(prev_ill));
            check("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
            for (int n = 0; n < 6; n++) begin
                mon_idx = -1;
                for (int i = 0; i < sb.size(); i++)
                    if (mon_idx < 0 && sb[i].chan == n) mon_idx = i;
                check($sformatf("X_valid[%0d]", n), 64'(X_valid[n]), 64'(mon_idx >= 0));
                if (mon_idx >= 0 && X_valid[n]) begin
                    check($sformatf("X%0d data", n), xs[n], sb[mon_idx].data);
                    if (X_ready[n]) sb.delete(mon_idx);
                end
            end
            prev_ill = in_valid && (S > 3'd5);
            if (prev_ill && exp_drop < 255) exp_drop++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        S        = '0;
        A        = '0;
        in_valid = 1'b0;
        X_ready  = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst X_valid", 64'(X_valid), 64'h0);
        check("rst err", 64'(err), 64'h0);
        check("rst drop_cnt", 64'(drop_cnt), 64'h0);
        check("rst in_ready", 64'(in_ready), 64'h1);
        for (int n = 0; n < 6; n++) check($sformatf("rst X%0d", n), xs[n], 64'h0);

        // Reset mid-operation: X2 full, one drop counted, then async reset
        @(posedge clk); #1;
        X_ready = 6'b000000;
        send(3'd2, 64'hDEAD_BEEF_0000_0002, 1'b1);
        send(3'd6, 64'h0, 1'b1);
        @(negedge clk);
        check("pre-rst X2", X2, 64'hDEAD_BEEF_0000_0002);
        #2 reset = 1'b1;
        #1;
        check("mid-rst X_valid", 64'(X_valid), 64'h0);
        check("mid-rst X2", X2, 64'h0);
        check("mid-rst drop_cnt", 64'(drop_cnt), 64'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        S     = 3'd2;
        #1;
        check("post-rst in_ready", 64'(in_ready), 64'h1);

        // Basic route
        @(posedge clk); #1;
        X_ready = 6'b111111;
        send(3'd3, 64'h0123_4567_89AB_CDEF, 1'b1);
        @(negedge clk);
        check("route X_valid", 64'(X_valid), 64'(6'b001000));
        check("route X3", X3, 64'h0123_4567_89AB_CDEF);
        @(negedge clk);
        check("route drained", 64'(X_valid), 64'h0);

        // Backpressure on channel 1
        @(posedge clk); #1;
        X_ready = 6'b000000;
        send(3'd1, 64'h11, 1'b1);
        S = 3'd1; A = 64'h22; in_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("bp in_ready", 64'(in_ready), 64'h0);
            check("bp X1 hold", X1, 64'h11);
            @(posedge clk); #1;
        end
        X_ready = 6'b000010;
        send(3'd1, 64'h22, 1'b1);
        X_ready = 6'b000000;
        @(negedge clk);
        check("bp X_valid[1]", 64'(X_valid[1]), 64'h1);
        check("bp X1 new", X1, 64'h22);
        @(posedge clk); #1;
        X_ready = 6'b111111;
        @(posedge clk); #1;

        // Independence: X5 stalled, X0 still routable
        X_ready = 6'b000000;
        send(3'd5, 64'h55, 1'b1);
        send(3'd0, 64'hAA, 1'b1);
        @(negedge clk);
        check("indep X0", X0, 64'hAA);
        check("indep X5", X5, 64'h55);
        check("indep X_valid", 64'(X_valid), 64'(6'b100001));
        @(posedge clk); #1;
        X_ready = 6'b111111;
        @(posedge clk); #1;
        @(negedge clk);
        check("indep drained", 64'(X_valid), 64'h0);

        // Full streaming, one word per cycle to each channel
        @(posedge clk); #1;
        for (int n = 0; n < 6; n++) send(3'(n), 64'(n + 1), 1'b1);
        @(negedge clk);
        check("stream X5", X5, 64'h6);
        @(posedge clk); #1;

        // Illegal select storm with X4 held full and stalled
        X_ready = 6'b000000;
        send(3'd4, 64'h44, 1'b1);
        for (int i = 0; i < 300; i++) send(3'd7, 64'(i), 1'b1);
        @(negedge clk);
        check("ill drop_cnt sat", 64'(drop_cnt), 64'd255);
        check("ill X_valid", 64'(X_valid), 64'(6'b010000));
        check("ill X4", X4, 64'h44);
        @(negedge clk);
        check("ill err low", 64'(err), 64'h0);
        @(posedge clk); #1;
        X_ready = 6'b111111;
        repeat (3) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_demux_1x6_64bit
